// File: rtl/vit_pkg.sv
// Shared definitions for the Viterbi traceback slice.
//   state_e   : traceback controller FSM states
//   NODE_W    : trellis node width (K=3 code, 4 states)
//   FLAG_UP   : survivor flag selecting the upper predecessor
//   FLAG_LO   : survivor flag selecting the lower predecessor
//   NUM_NODES : number of trellis nodes
//   FLAGS_W   : width of one survivor-flag beat (2 bits per node)
package vit_pkg;

  localparam int unsigned NODE_W    = 2;
  localparam int unsigned NUM_NODES = 4;
  localparam int unsigned FLAGS_W   = 2 * NUM_NODES;

  localparam logic [1:0] FLAG_UP = 2'b10;
  localparam logic [1:0] FLAG_LO = 2'b01;

  typedef enum logic [1:0] {
    FILL,
    TRACE,
    OUTPUT,
    DONE
  } state_e;

endpackage

// File: rtl/traceback_ctrl_if.sv
// Handshake/data bundle between the ACS stage, the traceback controller and
// the downstream bit sink.
//   flag_valid, flags, flag_ready : survivor-flag beat handshake
//   end_node                      : traceback start node, taken with the last beat
//   data_out, data_valid          : decoded bit stream, no backpressure
//   busy, done, err               : status
// master: upstream/sink side; slave: traceback_ctrl side.
interface traceback_ctrl_if;
  import vit_pkg::*;

  logic               flag_valid;
  logic [FLAGS_W-1:0] flags;
  logic               flag_ready;
  logic [NODE_W-1:0]  end_node;
  logic               data_out;
  logic               data_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output flag_valid, flags, end_node,
    input  flag_ready, data_out, data_valid, busy, done, err
  );

  modport slave (
    input  flag_valid, flags, end_node,
    output flag_ready, data_out, data_valid, busy, done, err
  );

endinterface

// File: rtl/traceback_step.sv
// One combinational traceback step of the 4-state trellis.
//   node    : current node
//   flag    : 2-bit survivor flag of that node
//   pred    : predecessor node
//   dec_bit : decoded bit for this step (node[1])
//   invalid : flag is neither upper nor lower select
// Optional checker: TRACEBACK_ERR_EN. When undefined only flag[1] is looked at
// and invalid is tied 0.
module traceback_step
  import vit_pkg::*;
(
  input  logic [NODE_W-1:0] node,
  input  logic [1:0]        flag,
  output logic [NODE_W-1:0] pred,
  output logic              dec_bit,
  output logic              invalid
);

`ifdef TRACEBACK_ERR_EN
  always_comb begin
    dec_bit = node[1];
    invalid = (flag != FLAG_UP) && (flag != FLAG_LO);
    // Predecessor of {a,b} is {b,0} (upper) or {b,1} (lower); bad flags fall back to 00.
    if (invalid) begin
      pred = '0;
    end else begin
      pred = {node[0], (flag == FLAG_LO)};
    end
  end
`else
  logic unused_flag_lo;
  assign unused_flag_lo = flag[0];

  always_comb begin
    dec_bit = node[1];
    invalid = 1'b0;
    pred    = {node[0], ~flag[1]};
  end
`endif

endmodule

// File: rtl/traceback_ctrl.sv
// Viterbi traceback sequencer for the 4-state (K=3) code.
// Buffers one frame of survivor flags, walks the trellis backwards one step
// per cycle from end_node, then replays the decoded bits in time order.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : traceback_ctrl_if.slave (flag handshake, end_node, data, status)
// Parameters: FRAME_LEN (steps per frame, >= 2), CNT_W (counter width).
// Optional feature macro: TRACEBACK_ERR_EN (sticky invalid-flag error).
module traceback_ctrl
  import vit_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
  input logic             clk,
  input logic             rst,
  traceback_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NODE_W-1:0]   node_q, node_d;
  logic [FLAGS_W-1:0]  flag_buf [FRAME_LEN];
  logic [FRAME_LEN-1:0] bit_buf;
  logic                data_out_q, data_valid_q, done_q;

  logic                flag_ready, accept, wr_flag, wr_bit;
  logic [FLAGS_W-1:0]  cur_flags;
  logic [1:0]          sel;
  logic [NODE_W-1:0]   step_pred;
  logic                step_bit, step_invalid;

  // done_q keeps flag_ready low through the done cycle.
  assign flag_ready = (state_q == FILL) && !done_q;
  assign accept     = bus.flag_valid && flag_ready;
  assign cur_flags  = flag_buf[cnt_q];
  assign sel        = cur_flags[{node_q, 1'b0} +: 2];

  traceback_step u_step (
    .node    (node_q),
    .flag    (sel),
    .pred    (step_pred),
    .dec_bit (step_bit),
    .invalid (step_invalid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    node_d  = node_q;
    wr_flag = 1'b0;
    wr_bit  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          wr_flag = 1'b1;
          if (cnt_q == CNT_LAST) begin
            node_d  = bus.end_node;
            cnt_d   = CNT_LAST;
            state_d = TRACE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRACE: begin
        wr_bit = 1'b1;
        node_d = step_pred;
        if (cnt_q == '0) begin
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = FILL;
      end
      default: begin
        cnt_d   = '0;
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      node_q       <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      node_q       <= node_d;
      // Outputs lag the OUTPUT state by one cycle, so data_out is 0 when idle.
      data_valid_q <= (state_q == OUTPUT);
      data_out_q   <= (state_q == OUTPUT) && bit_buf[cnt_q];
      done_q       <= (state_q == DONE);
    end
  end

  // Frame buffers carry no reset; stale contents are always overwritten first.
  always_ff @(posedge clk) begin
    if (wr_flag) begin
      flag_buf[cnt_q] <= bus.flags;
    end
    if (wr_bit) begin
      bit_buf[cnt_q] <= step_bit;
    end
  end

`ifdef TRACEBACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state_q == TRACE) && step_invalid) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  // step_invalid is a constant 0 in this build.
  assign bus.err = step_invalid;
`endif

  assign bus.flag_ready = flag_ready;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q == TRACE) || (state_q == OUTPUT);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_traceback_ctrl.sv
// Self-checking bench for traceback_ctrl with FRAME_LEN=4.
// A frame-level model predicts every output from the cycle count since the
// last accepted beat; a negedge process compares the DUT against it each cycle.
// Directed frames add literal expectations on the decoded bits and latencies.
module tb_traceback_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  traceback_ctrl_if bus ();

  traceback_ctrl #(
    .FRAME_LEN (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- model ----------------
  int           cyc        = 0;
  bit           armed      = 1'b0;
  int           m_phase    = -1;   // -1: accepting flags; else cycles since last beat
  int           m_beats    = 0;
  int           m_err_phase = 1000;
  logic         m_err      = 1'b0;
  logic [7:0]   m_fl [N];
  logic [N-1:0] m_bits     = '0;
  int           last_acc_cyc = 0;

  // Predecessor table straight from the trellis definition.
  function automatic logic [1:0] pred_of(input logic [1:0] node, input bit upper);
    case (node)
      2'b00: pred_of = upper ? 2'b00 : 2'b01;
      2'b01: pred_of = upper ? 2'b10 : 2'b11;
      2'b10: pred_of = upper ? 2'b00 : 2'b01;
      default: pred_of = upper ? 2'b10 : 2'b11;
    endcase
  endfunction

  // bits[i] is the i-th bit out in time order; errp is the phase where err rises.
  function automatic void model_trace(input logic [7:0] f [N], input logic [1:0] en,
                                      output logic [N-1:0] bits, output int errp);
    logic [1:0] node;
    logic [1:0] sel;
    node = en;
    errp = 1000;
    bits = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel     = f[k][2*node +: 2];
      bits[k] = node[1];
`ifdef TRACEBACK_ERR_EN
      if (sel == 2'b10) node = pred_of(node, 1'b1);
      else if (sel == 2'b01) node = pred_of(node, 1'b0);
      else begin
        node = 2'b00;
        if (errp == 1000) errp = N - k;
      end
`else
      node = pred_of(node, sel[1]);
`endif
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_phase = -1;
      m_beats = 0;
      m_err   = 1'b0;
      armed   = 1'b1;
    end else if (m_phase < 0) begin
      if (bus.flag_valid) begin
        m_fl[m_beats] = bus.flags;
        if (m_beats == N - 1) begin
          model_trace(m_fl, bus.end_node, m_bits, m_err_phase);
          m_phase      = 0;
          m_beats      = 0;
          last_acc_cyc = cyc;
        end else begin
          m_beats++;
        end
      end
    end else begin
      m_phase++;
      if (m_phase > 2 * N + 1) m_phase = -1;
      else if (m_phase >= m_err_phase) m_err = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [5:0] exp_v, act_v;
  always @(negedge clk) begin
    if (armed) begin
      logic e_rdy, e_busy, e_dv, e_do, e_done;
      e_rdy  = (m_phase < 0);
      e_busy = (m_phase >= 0) && (m_phase <= 2 * N - 1);
      e_dv   = (m_phase >= N + 1) && (m_phase <= 2 * N);
      e_do   = e_dv ? m_bits[m_phase - N - 1] : 1'b0;
      e_done = (m_phase == 2 * N + 1);
      exp_v  = {e_rdy, e_busy, e_dv, e_do, e_done, m_err};
      act_v  = {bus.flag_ready, bus.busy, bus.data_valid, bus.data_out, bus.done, bus.err};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_outputs cyc=%0d phase=%0d {rdy,busy,dv,do,done,err} got=%b want=%b",
                 cyc, m_phase, act_v, exp_v);
      end
    end
  end

  // ---------------- output capture ----------------
  logic got[$];
  int   first_dv_cyc = 0;
  int   last_dv_cyc  = 0;
  int   done_cyc     = 0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      if (got.size() == 0) first_dv_cyc = cyc;
      got.push_back(bus.data_out);
      last_dv_cyc = cyc;
    end
  end

  function automatic int pack_got();
    int v = 0;
    foreach (got[i]) if (got[i] === 1'b1) v |= (1 << i);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Presents the frame beat by beat; returns how many cycles beat 0 waited.
  task automatic send_frame(input logic [7:0] f [N], input logic [1:0] en, input bit hold,
                            output int wait0);
    int n;
    wait0 = 0;
    for (int i = 0; i < N; i++) begin
      bus.flags      = f[i];
      bus.end_node   = en;
      bus.flag_valid = 1'b1;
      n = 0;
      while (bus.flag_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        miscompares++;
        $display("FAIL flag_ready_timeout beat=%0d got=0 want=1", i);
      end
      if (i == 0) wait0 = n;
      @(negedge clk);
    end
    if (!hold) bus.flag_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL done_timeout got=0 want=1");
    end
    done_cyc = cyc;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]   fr_up [N];
  logic [7:0]   fr_enc [N];
  logic [7:0]   fr_bad [N];
  logic [N-1:0] pin_bits;
  int           pin_errp;
  int           w;

  initial begin
    fr_up  = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    fr_enc = '{8'hAA, 8'hAA, 8'h9A, 8'hAA};
    fr_bad = '{8'hAA, 8'hAA, 8'h8A, 8'hAA};

    // Pin the model with hand-traced results.
    model_trace(fr_up, 2'b00, pin_bits, pin_errp);
    chk("model_upper", int'(pin_bits), 'h0);
    model_trace(fr_enc, 2'b11, pin_bits, pin_errp);
    chk("model_encoded", int'(pin_bits), 'hD);
    model_trace(fr_up, 2'b10, pin_bits, pin_errp);
    chk("model_end10", int'(pin_bits), 'h8);
    model_trace(fr_bad, 2'b11, pin_bits, pin_errp);
`ifdef TRACEBACK_ERR_EN
    chk("model_invalid", int'(pin_bits), 'hC);
    chk("model_err_phase", pin_errp, 2);
`else
    chk("model_invalid", int'(pin_bits), 'hD);
`endif

    // Reset.
    rst            = 1'b0;
    bus.flag_valid = 1'b0;
    bus.flags      = '0;
    bus.end_node   = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        int'({bus.flag_ready, bus.busy, bus.data_valid, bus.data_out, bus.done, bus.err}),
        'h20);
    rst = 1'b1;
    @(negedge clk);

    // All-upper frame.
    got.delete();
    send_frame(fr_up, 2'b00, 1'b0, w);
    wait_done();
    chk("upper_count", got.size(), N);
    chk("upper_bits", pack_got(), 'h0);
    repeat (2) @(negedge clk);

    // Encoded frame 1,0,1,1.
    got.delete();
    send_frame(fr_enc, 2'b11, 1'b0, w);
    wait_done();
    chk("enc_count", got.size(), N);
    chk("enc_bits", pack_got(), 'hD);
    chk("enc_first_latency", first_dv_cyc - last_acc_cyc, N + 1);
    chk("enc_last_latency", last_dv_cyc - last_acc_cyc, 2 * N);
    chk("enc_done_after_last", done_cyc - last_dv_cyc, 1);
    repeat (3) @(negedge clk);

    // Backpressure: flag_valid never drops between two frames.
    got.delete();
    send_frame(fr_enc, 2'b11, 1'b1, w);
    send_frame(fr_up, 2'b00, 1'b0, w);
    chk("bp_ready_low_cycles", w, 2 * N + 2);
    wait_done();
    chk("bp_bits", pack_got(), 'h0D);

    // Reset in OUTPUT after two bits.
    got.delete();
    send_frame(fr_enc, 2'b11, 1'b0, w);
    w = 0;
    while (got.size() < 2 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("midrst_two_bits", got.size(), 2);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_dv_busy", int'({bus.data_valid, bus.busy}), 0);
    rst = 1'b1;
    got.delete();
    send_frame(fr_up, 2'b10, 1'b0, w);
    wait_done();
    chk("midrst_next_bits", pack_got(), 'h8);
    repeat (2) @(negedge clk);

    // Invalid flag on step 2.
    got.delete();
    send_frame(fr_bad, 2'b11, 1'b0, w);
    wait_done();
`ifdef TRACEBACK_ERR_EN
    chk("invalid_bits", pack_got(), 'hC);
    chk("invalid_err_sticky", int'(bus.err), 1);
`else
    chk("invalid_bits", pack_got(), 'hD);
    chk("invalid_err_tied", int'(bus.err), 0);
`endif
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traceback_ctrl.md
# traceback_ctrl

- Sequences the Viterbi decoder's traceback for the 4-state (K=3) code.
- Buffers one frame of per-step survivor flags from the add-compare-select stage.
- Walks the trellis backwards, one step per cycle, from a supplied end node, using a combinational traceback-step sub-module.
- Replays the recovered bits in forward (time) order to the downstream sink.

## Interface
- FRAME_LEN, 16: trellis steps per frame; ≥ 2.
- CNT_W, $clog2(FRAME_LEN): step counter / buffer address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- flag_valid  in  1  survivor-flag beat valid.
- flags  in  8  {flag(node11), flag(node10), flag(node01), flag(node00)}; 2 bits per node.
- flag_ready  out  1  block accepts a flag beat.
- end_node  in  2  traceback start node; sampled with the last flag beat of a frame.
- data_out  out  1  decoded bit.
- data_valid  out  1  data_out valid; no backpressure.
- busy  out  1  high in TRACE or OUTPUT.
- done  out  1  one-cycle pulse after the last bit of a frame.
- err  out  1  sticky invalid-flag indicator; cleared only by reset.

## Operation
- Flag code: 2'b10 selects the upper predecessor; 2'b01 selects the lower predecessor; 2'b00 and 2'b11 are invalid.
- Traceback step (node, flag → predecessor, bit):
  - 00: 10→(00,0), 01→(01,0)
  - 01: 10→(10,0), 01→(11,0)
  - 10: 10→(00,1), 01→(01,1)
  - 11: 10→(10,1), 01→(11,1)
  - The bit is node[1].
- FSM states: FILL, TRACE, OUTPUT, DONE.
- FILL:
  - flag_ready=1.
  - Each beat with flag_valid&flag_ready writes flags to flag_buf[cnt]; cnt increments.
  - On the beat where cnt=FRAME_LEN-1: node_q←end_node, cnt←FRAME_LEN-1, go to TRACE.
- TRACE, one step per cycle:
  - sel = flag_buf[cnt][2*node_q+:2].
  - bit_buf[cnt]←step bit; node_q←predecessor.
  - If cnt=0, cnt←0 and go to OUTPUT; else cnt decrements.
- OUTPUT, one bit per cycle:
  - data_valid=1, data_out=bit_buf[cnt].
  - At cnt=FRAME_LEN-1, go to DONE; else cnt increments.
- DONE: done=1 for one cycle; cnt←0; go to FILL.
- Flags are not accepted outside FILL (flag_ready=0). Input beats presented then are ignored; the upstream holds them.
- Counter wrap: cnt never exceeds FRAME_LEN-1. Transitions are decided on cnt equality, not overflow.

## Timing
- Reset state:
  - FILL, cnt=0, node_q=00.
  - flag_ready=1 after reset; data_out=0, data_valid=0, busy=0, done=0, err=0.
  - Buffer contents undefined.
- Reset mid-frame (any state): abandon the frame; no partial output; next cycle behaves as post-reset.
- Latency from the accepting edge of the last flag beat:
  - first data_valid after FRAME_LEN+1 cycles;
  - last bit after 2·FRAME_LEN cycles;
  - done on the following cycle.
- Frame period ≥ 3·FRAME_LEN+1 cycles.
- flag_ready deasserts in the cycle after the last beat is accepted and reasserts the cycle after done.
- data_out and data_valid are registered; data_out=0 when data_valid=0.

## Configuration
- Macro: TRACEBACK_ERR_EN.
- Defined:
  - an invalid sel in TRACE sets err on the next edge;
  - that step uses predecessor 00 with bit node[1];
  - traceback continues.
- Undefined:
  - err tied 0;
  - flag[1] alone selects the path: 1=upper, 0=lower;
  - no checker logic is generated.

## Structure
- Shared package vit_pkg:
  - state enum {FILL, TRACE, OUTPUT, DONE};
  - NODE_W=2, FLAG_UP=2'b10, FLAG_LO=2'b01, NUM_NODES=4.
- Sub-module traceback_step: combinational (node, flag) → (pred, bit, invalid); instantiated once.
- flag_buf and bit_buf: register arrays in traceback_ctrl.

## Test plan
All cases use FRAME_LEN=4.
- Reset:
  - Stimulus: rst=0 for 2 cycles, then release.
  - Required: all outputs 0 except flag_ready=1; no data_valid before 4 beats.
- All-upper frame:
  - Stimulus: flags 8'hAA ×4, end_node=00.
  - Required: data_out 0,0,0,0 on 4 consecutive data_valid cycles; done one cycle later.
- Encoded frame:
  - Stimulus: source bits 1,0,1,1; flags AA, AA, 9A, AA; end_node=11.
  - Required: output 1,0,1,1 in order.
  - Required: first data_valid exactly 5 cycles after the last accepted beat.
- Backpressure:
  - Stimulus: flag_valid held high continuously.
  - Required: flag_ready low from the cycle after beat 4 through done.
  - Required: the next frame's first beat is accepted the cycle after done.
- Mid-frame reset:
  - Stimulus: rst asserted during OUTPUT after 2 bits.
  - Required: data_valid drops next cycle; busy=0; a new full frame decodes correctly.
- Invalid flag (TRACEBACK_ERR_EN):
  - Stimulus: step-2 flags 8'h8A with end_node=11.
  - Required: err rises during TRACE and stays high.
  - Required: the frame still completes with done.
